// File: rtl/axi_arb_pkg.sv
// ----------------------------------------------------------------------------
// axi_arb_pkg
// Shared types and constants for the 2:1 AXI4 round-robin arbiter.
//   w_state_e : write-path FSM states (IDLE -> ADDR -> DATA -> RESP)
//   r_state_e : read-path FSM states  (IDLE -> ADDR -> DATA)
//   OKAY/SLVERR : AXI response codes, INCR : AXI burst type
// ----------------------------------------------------------------------------
package axi_arb_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } r_state_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] INCR   = 2'b01;

endpackage

// File: rtl/axi_rr_arbiter_2to1_rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin picker with a registered last-grant pointer.
//   clock, reset : clock and synchronous active-high reset
//   req_i[1:0]   : request lines (bit K = master K)
//   adv_i        : a transaction has completed; record adv_idx_i as last grant
//   adv_idx_i    : index of the master whose transaction completed
//   any_o        : at least one request present
//   pick_o       : index to grant this cycle (combinational)
// The pointer resets to 1 so that master 0 wins the first contention.
// ----------------------------------------------------------------------------
module rr_arb2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       adv_i,
    input  logic       adv_idx_i,
    output logic       any_o,
    output logic       pick_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        last_d = last_q;
        if (adv_i) begin
            last_d = adv_idx_i;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    assign any_o  = |req_i;
    // Both requesting: take the one not served last; otherwise the sole requester.
    assign pick_o = (&req_i) ? ~last_q : req_i[1];

endmodule

// File: rtl/axi_rr_arbiter_2to1.sv
// ----------------------------------------------------------------------------
// axi_rr_arbiter_2to1
// Shares one AXI4 slave port between two AXI4 masters s0 and s1. Write
// (AW/W/B) and read (AR/R) paths are arbitrated independently, round-robin,
// one outstanding transaction per path. IDs pass through unmodified; responses
// are routed on the latched grant.
// Ports:
//   clock, reset          : clock, synchronous active-high reset
//   s0_*/s1_*             : master-side AXI4 ports (AW, W, B, AR, R)
//   m_*                   : slave-side AXI4 port
//   err_wlast             : one-cycle pulse after a W beat whose wlast does not
//                           agree with the beat count implied by awlen
// ----------------------------------------------------------------------------
module axi_rr_arbiter_2to1
    import axi_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 12,
    parameter int ID_WIDTH   = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    // master 0
    input  logic                    s0_awvalid,
    input  logic [ID_WIDTH-1:0]     s0_awid,
    input  logic [ADDR_WIDTH-1:0]   s0_awaddr,
    input  logic [7:0]              s0_awlen,
    input  logic [2:0]              s0_awsize,
    input  logic [1:0]              s0_awburst,
    output logic                    s0_awready,
    input  logic                    s0_wvalid,
    input  logic [DATA_WIDTH-1:0]   s0_wdata,
    input  logic [DATA_WIDTH/8-1:0] s0_wstrb,
    input  logic                    s0_wlast,
    output logic                    s0_wready,
    output logic                    s0_bvalid,
    output logic [ID_WIDTH-1:0]     s0_bid,
    output logic [1:0]              s0_bresp,
    input  logic                    s0_bready,
    input  logic                    s0_arvalid,
    input  logic [ID_WIDTH-1:0]     s0_arid,
    input  logic [ADDR_WIDTH-1:0]   s0_araddr,
    input  logic [7:0]              s0_arlen,
    input  logic [2:0]              s0_arsize,
    input  logic [1:0]              s0_arburst,
    output logic                    s0_arready,
    output logic                    s0_rvalid,
    output logic [ID_WIDTH-1:0]     s0_rid,
    output logic [DATA_WIDTH-1:0]   s0_rdata,
    output logic [1:0]              s0_rresp,
    output logic                    s0_rlast,
    input  logic                    s0_rready,
    // master 1
    input  logic                    s1_awvalid,
    input  logic [ID_WIDTH-1:0]     s1_awid,
    input  logic [ADDR_WIDTH-1:0]   s1_awaddr,
    input  logic [7:0]              s1_awlen,
    input  logic [2:0]              s1_awsize,
    input  logic [1:0]              s1_awburst,
    output logic                    s1_awready,
    input  logic                    s1_wvalid,
    input  logic [DATA_WIDTH-1:0]   s1_wdata,
    input  logic [DATA_WIDTH/8-1:0] s1_wstrb,
    input  logic                    s1_wlast,
    output logic                    s1_wready,
    output logic                    s1_bvalid,
    output logic [ID_WIDTH-1:0]     s1_bid,
    output logic [1:0]              s1_bresp,
    input  logic                    s1_bready,
    input  logic                    s1_arvalid,
    input  logic [ID_WIDTH-1:0]     s1_arid,
    input  logic [ADDR_WIDTH-1:0]   s1_araddr,
    input  logic [7:0]              s1_arlen,
    input  logic [2:0]              s1_arsize,
    input  logic [1:0]              s1_arburst,
    output logic                    s1_arready,
    output logic                    s1_rvalid,
    output logic [ID_WIDTH-1:0]     s1_rid,
    output logic [DATA_WIDTH-1:0]   s1_rdata,
    output logic [1:0]              s1_rresp,
    output logic                    s1_rlast,
    input  logic                    s1_rready,
    // slave port
    output logic                    m_awvalid,
    output logic [ID_WIDTH-1:0]     m_awid,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [7:0]              m_awlen,
    output logic [2:0]              m_awsize,
    output logic [1:0]              m_awburst,
    input  logic                    m_awready,
    output logic                    m_wvalid,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wlast,
    input  logic                    m_wready,
    input  logic                    m_bvalid,
    input  logic [ID_WIDTH-1:0]     m_bid,
    input  logic [1:0]              m_bresp,
    output logic                    m_bready,
    output logic                    m_arvalid,
    output logic [ID_WIDTH-1:0]     m_arid,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic [7:0]              m_arlen,
    output logic [2:0]              m_arsize,
    output logic [1:0]              m_arburst,
    input  logic                    m_arready,
    input  logic                    m_rvalid,
    input  logic [ID_WIDTH-1:0]     m_rid,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rlast,
    output logic                    m_rready,
    output logic                    err_wlast
);

    // ------------------------------------------------------------------
    // Write path state
    // ------------------------------------------------------------------
    w_state_e   w_state_q, w_state_d;
    logic       wgnt_q, wgnt_d;
    logic [7:0] wcnt_q, wcnt_d;
    logic       err_q, err_d;
    logic       w_adv, w_any, w_pick;
    logic       w_in_addr, w_in_data, w_in_resp;
    logic       sel_wvalid, sel_bready;
    logic       w_hs, b_hs;

    // ------------------------------------------------------------------
    // Read path state
    // ------------------------------------------------------------------
    r_state_e   r_state_q, r_state_d;
    logic       rgnt_q, rgnt_d;
    logic       r_adv, r_any, r_pick;
    logic       r_in_addr, r_in_data;
    logic       sel_rready;
    logic       r_hs;

    rr_arb2 u_warb (
        .clock     (clock),
        .reset     (reset),
        .req_i     ({s1_awvalid, s0_awvalid}),
        .adv_i     (w_adv),
        .adv_idx_i (wgnt_q),
        .any_o     (w_any),
        .pick_o    (w_pick)
    );

    rr_arb2 u_rarb (
        .clock     (clock),
        .reset     (reset),
        .req_i     ({s1_arvalid, s0_arvalid}),
        .adv_i     (r_adv),
        .adv_idx_i (rgnt_q),
        .any_o     (r_any),
        .pick_o    (r_pick)
    );

    // ------------------------------------------------------------------
    // Write channel muxing on the latched grant
    // ------------------------------------------------------------------
    assign w_in_addr = (w_state_q == W_ADDR);
    assign w_in_data = (w_state_q == W_DATA);
    assign w_in_resp = (w_state_q == W_RESP);

    // The granted master was seen asserting awvalid in W_IDLE and AXI keeps it
    // asserted until the handshake, so m_awvalid comes from state alone.
    assign m_awvalid  = w_in_addr;
    assign m_awid     = wgnt_q ? s1_awid    : s0_awid;
    assign m_awaddr   = wgnt_q ? s1_awaddr  : s0_awaddr;
    assign m_awlen    = wgnt_q ? s1_awlen   : s0_awlen;
    assign m_awsize   = wgnt_q ? s1_awsize  : s0_awsize;
    assign m_awburst  = wgnt_q ? s1_awburst : s0_awburst;
    assign s0_awready = w_in_addr & ~wgnt_q & m_awready;
    assign s1_awready = w_in_addr &  wgnt_q & m_awready;

    assign sel_wvalid = wgnt_q ? s1_wvalid : s0_wvalid;
    assign m_wvalid   = w_in_data & sel_wvalid;
    assign m_wdata    = wgnt_q ? s1_wdata : s0_wdata;
    assign m_wstrb    = wgnt_q ? s1_wstrb : s0_wstrb;
    assign m_wlast    = wgnt_q ? s1_wlast : s0_wlast;
    assign s0_wready  = w_in_data & ~wgnt_q & m_wready;
    assign s1_wready  = w_in_data &  wgnt_q & m_wready;
    assign w_hs       = m_wvalid & m_wready;

    assign sel_bready = wgnt_q ? s1_bready : s0_bready;
    assign m_bready   = w_in_resp & sel_bready;
    assign s0_bvalid  = w_in_resp & ~wgnt_q & m_bvalid;
    assign s1_bvalid  = w_in_resp &  wgnt_q & m_bvalid;
    assign s0_bid     = m_bid;
    assign s1_bid     = m_bid;
    assign s0_bresp   = m_bresp;
    assign s1_bresp   = m_bresp;
    assign b_hs       = w_in_resp & m_bvalid & sel_bready;

    assign err_wlast  = err_q;

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = w_state_q;
        wgnt_d    = wgnt_q;
        wcnt_d    = wcnt_q;
        err_d     = 1'b0;
        w_adv     = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (w_any) begin
                    wgnt_d    = w_pick;
                    w_state_d = W_ADDR;
                end
            end
            W_ADDR: begin
                if (m_awready) begin
                    wcnt_d    = m_awlen;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    // Counter holds remaining beats after this one; it saturates
                    // at 0 when a master overruns its burst.
                    if (wcnt_q != 8'd0) begin
                        wcnt_d = wcnt_q - 8'd1;
                    end
                    err_d = m_wlast ? (wcnt_q != 8'd0) : (wcnt_q == 8'd0);
                    if (m_wlast) begin
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (b_hs) begin
                    w_adv     = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            wgnt_q    <= 1'b0;
            wcnt_q    <= 8'd0;
            err_q     <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            wgnt_q    <= wgnt_d;
            wcnt_q    <= wcnt_d;
            err_q     <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Read channel muxing on the latched grant
    // ------------------------------------------------------------------
    assign r_in_addr = (r_state_q == R_ADDR);
    assign r_in_data = (r_state_q == R_DATA);

    assign m_arvalid  = r_in_addr;
    assign m_arid     = rgnt_q ? s1_arid    : s0_arid;
    assign m_araddr   = rgnt_q ? s1_araddr  : s0_araddr;
    assign m_arlen    = rgnt_q ? s1_arlen   : s0_arlen;
    assign m_arsize   = rgnt_q ? s1_arsize  : s0_arsize;
    assign m_arburst  = rgnt_q ? s1_arburst : s0_arburst;
    assign s0_arready = r_in_addr & ~rgnt_q & m_arready;
    assign s1_arready = r_in_addr &  rgnt_q & m_arready;

    assign sel_rready = rgnt_q ? s1_rready : s0_rready;
    assign m_rready   = r_in_data & sel_rready;
    assign s0_rvalid  = r_in_data & ~rgnt_q & m_rvalid;
    assign s1_rvalid  = r_in_data &  rgnt_q & m_rvalid;
    assign s0_rid     = m_rid;
    assign s1_rid     = m_rid;
    assign s0_rdata   = m_rdata;
    assign s1_rdata   = m_rdata;
    assign s0_rresp   = m_rresp;
    assign s1_rresp   = m_rresp;
    assign s0_rlast   = m_rlast;
    assign s1_rlast   = m_rlast;
    assign r_hs       = r_in_data & m_rvalid & sel_rready;

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------
    always_comb begin
        r_state_d = r_state_q;
        rgnt_d    = rgnt_q;
        r_adv     = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (r_any) begin
                    rgnt_d    = r_pick;
                    r_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                if (m_arready) begin
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (r_hs && m_rlast) begin
                    r_adv     = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            rgnt_q    <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            rgnt_q    <= rgnt_d;
        end
    end

endmodule

// File: tb/tb_axi_rr_arbiter_2to1.sv
module tb_axi_rr_arbiter_2to1;
    import axi_arb_pkg::*;

    localparam int DW  = 64;
    localparam int AWD = 12;
    localparam int IW  = 4;

    logic clock = 1'b0;
    logic reset;

    logic s0_awvalid, s0_awready, s0_wvalid, s0_wlast, s0_wready, s0_bvalid, s0_bready;
    logic s0_arvalid, s0_arready, s0_rvalid, s0_rlast, s0_rready;
    logic [IW-1:0] s0_awid, s0_bid, s0_arid, s0_rid;
    logic [AWD-1:0] s0_awaddr, s0_araddr;
    logic [7:0] s0_awlen, s0_arlen;
    logic [2:0] s0_awsize, s0_arsize;
    logic [1:0] s0_awburst, s0_arburst, s0_bresp, s0_rresp;
    logic [DW-1:0] s0_wdata, s0_rdata;
    logic [DW/8-1:0] s0_wstrb;

    logic s1_awvalid, s1_awready, s1_wvalid, s1_wlast, s1_wready, s1_bvalid, s1_bready;
    logic s1_arvalid, s1_arready, s1_rvalid, s1_rlast, s1_rready;
    logic [IW-1:0] s1_awid, s1_bid, s1_arid, s1_rid;
    logic [AWD-1:0] s1_awaddr, s1_araddr;
    logic [7:0] s1_awlen, s1_arlen;
    logic [2:0] s1_awsize, s1_arsize;
    logic [1:0] s1_awburst, s1_arburst, s1_bresp, s1_rresp;
    logic [DW-1:0] s1_wdata, s1_rdata;
    logic [DW/8-1:0] s1_wstrb;

    logic m_awvalid, m_awready, m_wvalid, m_wlast, m_wready, m_bvalid, m_bready;
    logic m_arvalid, m_arready, m_rvalid, m_rlast, m_rready;
    logic [IW-1:0] m_awid, m_bid, m_arid, m_rid;
    logic [AWD-1:0] m_awaddr, m_araddr;
    logic [7:0] m_awlen, m_arlen;
    logic [2:0] m_awsize, m_arsize;
    logic [1:0] m_awburst, m_arburst, m_bresp, m_rresp;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [DW/8-1:0] m_wstrb;
    logic err_wlast;

    int checks = 0;
    int errors = 0;

    axi_rr_arbiter_2to1 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWD), .ID_WIDTH(IW)) dut (
        .clock(clock), .reset(reset),
        .s0_awvalid(s0_awvalid), .s0_awid(s0_awid), .s0_awaddr(s0_awaddr), .s0_awlen(s0_awlen),
        .s0_awsize(s0_awsize), .s0_awburst(s0_awburst), .s0_awready(s0_awready),
        .s0_wvalid(s0_wvalid), .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wlast(s0_wlast),
        .s0_wready(s0_wready), .s0_bvalid(s0_bvalid), .s0_bid(s0_bid), .s0_bresp(s0_bresp),
        .s0_bready(s0_bready), .s0_arvalid(s0_arvalid), .s0_arid(s0_arid), .s0_araddr(s0_araddr),
        .s0_arlen(s0_arlen), .s0_arsize(s0_arsize), .s0_arburst(s0_arburst), .s0_arready(s0_arready),
        .s0_rvalid(s0_rvalid), .s0_rid(s0_rid), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp),
        .s0_rlast(s0_rlast), .s0_rready(s0_rready),
        .s1_awvalid(s1_awvalid), .s1_awid(s1_awid), .s1_awaddr(s1_awaddr), .s1_awlen(s1_awlen),
        .s1_awsize(s1_awsize), .s1_awburst(s1_awburst), .s1_awready(s1_awready),
        .s1_wvalid(s1_wvalid), .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wlast(s1_wlast),
        .s1_wready(s1_wready), .s1_bvalid(s1_bvalid), .s1_bid(s1_bid), .s1_bresp(s1_bresp),
        .s1_bready(s1_bready), .s1_arvalid(s1_arvalid), .s1_arid(s1_arid), .s1_araddr(s1_araddr),
        .s1_arlen(s1_arlen), .s1_arsize(s1_arsize), .s1_arburst(s1_arburst), .s1_arready(s1_arready),
        .s1_rvalid(s1_rvalid), .s1_rid(s1_rid), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp),
        .s1_rlast(s1_rlast), .s1_rready(s1_rready),
        .m_awvalid(m_awvalid), .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
        .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awready(m_awready),
        .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_wready(m_wready), .m_bvalid(m_bvalid), .m_bid(m_bid), .m_bresp(m_bresp),
        .m_bready(m_bready), .m_arvalid(m_arvalid), .m_arid(m_arid), .m_araddr(m_araddr),
        .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rlast(m_rlast), .m_rready(m_rready),
        .err_wlast(err_wlast)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        s0_awvalid = 0; s0_awid = '0; s0_awaddr = '0; s0_awlen = '0; s0_awsize = 3'd3; s0_awburst = INCR;
        s0_wvalid = 0; s0_wdata = '0; s0_wstrb = '1; s0_wlast = 0; s0_bready = 0;
        s0_arvalid = 0; s0_arid = '0; s0_araddr = '0; s0_arlen = '0; s0_arsize = 3'd3; s0_arburst = INCR;
        s0_rready = 0;
        s1_awvalid = 0; s1_awid = '0; s1_awaddr = '0; s1_awlen = '0; s1_awsize = 3'd3; s1_awburst = INCR;
        s1_wvalid = 0; s1_wdata = '0; s1_wstrb = '1; s1_wlast = 0; s1_bready = 0;
        s1_arvalid = 0; s1_arid = '0; s1_araddr = '0; s1_arlen = '0; s1_arsize = 3'd3; s1_arburst = INCR;
        s1_rready = 0;
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bid = '0; m_bresp = OKAY;
        m_arready = 0; m_rvalid = 0; m_rid = '0; m_rdata = '0; m_rresp = OKAY; m_rlast = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        settle();
        checks++;
        if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_m_ctrl: got %b expected 00000", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready});
        end
        checks++;
        if ({s0_awready, s0_wready, s0_bvalid, s0_arready, s0_rvalid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_s0_ctrl: got %b expected 00000", {s0_awready, s0_wready, s0_bvalid, s0_arready, s0_rvalid});
        end
        checks++;
        if ({s1_awready, s1_wready, s1_bvalid, s1_arready, s1_rvalid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_s1_ctrl: got %b expected 00000", {s1_awready, s1_wready, s1_bvalid, s1_arready, s1_rvalid});
        end
        checks++;
        if (err_wlast !== 1'b0) begin
            errors++;
            $display("FAIL reset_err_wlast: got %b expected 0", err_wlast);
        end
    endtask

    task automatic test_single_write();
        int beats;
        beats = 0;
        s0_awvalid = 1; s0_awid = 4'h5; s0_awaddr = 12'h100; s0_awlen = 8'd3;
        s0_wvalid = 1; s0_wdata = 64'h1000; s0_wlast = 0; m_wready = 1;
        settle();
        checks++;
        if (m_awvalid !== 1'b0) begin
            errors++;
            $display("FAIL single_aw_no_comb: got %b expected 0", m_awvalid);
        end
        checks++;
        if ({s0_wready, m_wvalid} !== 2'b00) begin
            errors++;
            $display("FAIL single_w_stall_idle: got %b expected 00", {s0_wready, m_wvalid});
        end
        tick();
        checks++;
        if ({m_awvalid, m_awid, m_awaddr, m_awlen} !== {1'b1, 4'h5, 12'h100, 8'd3}) begin
            errors++;
            $display("FAIL single_aw_fwd: got %h expected %h", {m_awvalid, m_awid, m_awaddr, m_awlen}, {1'b1, 4'h5, 12'h100, 8'd3});
        end
        checks++;
        if ({s0_wready, m_wvalid} !== 2'b00) begin
            errors++;
            $display("FAIL single_w_stall_addr: got %b expected 00", {s0_wready, m_wvalid});
        end
        m_awready = 1;
        settle();
        checks++;
        if ({s0_awready, s1_awready} !== 2'b10) begin
            errors++;
            $display("FAIL single_awready: got %b expected 10", {s0_awready, s1_awready});
        end
        tick();
        s0_awvalid = 0; m_awready = 0;
        for (int i = 0; i < 4; i++) begin
            s0_wdata = 64'h1000 + 64'(i);
            s0_wlast = (i == 3);
            settle();
            checks++;
            if ({m_wvalid, s0_wready, m_wlast, m_wdata} !== {1'b1, 1'b1, 1'(i == 3), 64'h1000 + 64'(i)}) begin
                errors++;
                $display("FAIL single_w_beat%0d: got %h expected %h", i, {m_wvalid, s0_wready, m_wlast, m_wdata},
                         {1'b1, 1'b1, 1'(i == 3), 64'h1000 + 64'(i)});
            end
            if (m_wvalid && m_wready) beats++;
            tick();
            checks++;
            if (err_wlast !== 1'b0) begin
                errors++;
                $display("FAIL single_err_wlast%0d: got %b expected 0", i, err_wlast);
            end
        end
        s0_wvalid = 0; s0_wlast = 0; m_wready = 0;
        checks++;
        if (beats != 4) begin
            errors++;
            $display("FAIL single_beat_count: got %0d expected 4", beats);
        end
        m_bvalid = 1; m_bid = 4'h5; m_bresp = OKAY; s0_bready = 1;
        settle();
        checks++;
        if ({s0_bvalid, s0_bid, s0_bresp, m_bready, s1_bvalid} !== {1'b1, 4'h5, OKAY, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL single_b_route: got %h expected %h", {s0_bvalid, s0_bid, s0_bresp, m_bready, s1_bvalid},
                     {1'b1, 4'h5, OKAY, 1'b1, 1'b0});
        end
        tick();
        m_bvalid = 0; s0_bready = 0;
        settle();
        checks++;
        if ({m_bready, s0_bvalid} !== 2'b00) begin
            errors++;
            $display("FAIL single_b_done: got %b expected 00", {m_bready, s0_bvalid});
        end
    endtask

    // Both masters keep requesting back-to-back; grants must alternate 0,1,0,1.
    task automatic test_contention();
        logic exp;
        do_reset();
        s0_awvalid = 1; s0_awid = 4'h1; s0_awaddr = 12'h200; s0_awlen = 8'd0;
        s1_awvalid = 1; s1_awid = 4'h2; s1_awaddr = 12'h300; s1_awlen = 8'd0;
        s0_wvalid = 1; s0_wdata = 64'h5A0; s0_wlast = 1;
        s1_wvalid = 1; s1_wdata = 64'h5A1; s1_wlast = 1;
        s0_bready = 1; s1_bready = 1;
        for (int r = 0; r < 4; r++) begin
            exp = 1'(r & 1);
            tick();
            checks++;
            if ({m_awaddr, m_awid} !== (exp ? {12'h300, 4'h2} : {12'h200, 4'h1})) begin
                errors++;
                $display("FAIL contention_aw_round%0d: got %h expected %h", r, {m_awaddr, m_awid},
                         exp ? {12'h300, 4'h2} : {12'h200, 4'h1});
            end
            m_awready = 1;
            settle();
            checks++;
            if ({s0_awready, s1_awready} !== {~exp, exp}) begin
                errors++;
                $display("FAIL contention_awready_round%0d: got %b expected %b", r, {s0_awready, s1_awready}, {~exp, exp});
            end
            tick();
            m_awready = 0; m_wready = 1;
            settle();
            checks++;
            if ({s0_wready, s1_wready, m_wdata} !== {~exp, exp, (exp ? 64'h5A1 : 64'h5A0)}) begin
                errors++;
                $display("FAIL contention_w_round%0d: got %h expected %h", r, {s0_wready, s1_wready, m_wdata},
                         {~exp, exp, (exp ? 64'h5A1 : 64'h5A0)});
            end
            tick();
            m_wready = 0; m_bvalid = 1; m_bid = exp ? 4'h2 : 4'h1;
            settle();
            checks++;
            if ({s0_bvalid, s1_bvalid} !== {~exp, exp}) begin
                errors++;
                $display("FAIL contention_b_round%0d: got %b expected %b", r, {s0_bvalid, s1_bvalid}, {~exp, exp});
            end
            tick();
            m_bvalid = 0;
        end
        clear_inputs();
    endtask

    task automatic test_concurrent();
        s1_arvalid = 1; s1_arid = 4'h3; s1_araddr = 12'h040; s1_arlen = 8'd7;
        s0_awvalid = 1; s0_awid = 4'h6; s0_awaddr = 12'h080; s0_awlen = 8'd0;
        tick();
        checks++;
        if ({m_arvalid, m_arid, m_araddr, m_arlen, m_awvalid, m_awid} !== {1'b1, 4'h3, 12'h040, 8'd7, 1'b1, 4'h6}) begin
            errors++;
            $display("FAIL concurrent_addr: got %h expected %h", {m_arvalid, m_arid, m_araddr, m_arlen, m_awvalid, m_awid},
                     {1'b1, 4'h3, 12'h040, 8'd7, 1'b1, 4'h6});
        end
        m_arready = 1; m_awready = 1;
        settle();
        checks++;
        if ({s1_arready, s0_arready, s0_awready, s1_awready} !== 4'b1010) begin
            errors++;
            $display("FAIL concurrent_readies: got %b expected 1010", {s1_arready, s0_arready, s0_awready, s1_awready});
        end
        tick();
        s1_arvalid = 0; s0_awvalid = 0; m_arready = 0; m_awready = 0;
        s1_rready = 1; s0_rready = 1; s0_bready = 1;
        for (int i = 0; i < 8; i++) begin
            m_rvalid = 1; m_rid = 4'h3; m_rdata = 64'hD0 + 64'(i); m_rlast = (i == 7); m_rresp = OKAY;
            s0_wvalid = (i == 0); s0_wlast = 1; s0_wdata = 64'hEE; m_wready = (i == 0);
            m_bvalid = (i == 1); m_bid = 4'h6;
            settle();
            checks++;
            if ({s1_rvalid, s0_rvalid, s1_rid, s1_rlast, m_rready, s1_rdata} !==
                {1'b1, 1'b0, 4'h3, 1'(i == 7), 1'b1, 64'hD0 + 64'(i)}) begin
                errors++;
                $display("FAIL concurrent_r_beat%0d: got %h expected %h", i,
                         {s1_rvalid, s0_rvalid, s1_rid, s1_rlast, m_rready, s1_rdata},
                         {1'b1, 1'b0, 4'h3, 1'(i == 7), 1'b1, 64'hD0 + 64'(i)});
            end
            if (i == 0) begin
                checks++;
                if ({s0_wready, m_wvalid, s1_wready} !== 3'b110) begin
                    errors++;
                    $display("FAIL concurrent_w: got %b expected 110", {s0_wready, m_wvalid, s1_wready});
                end
            end
            if (i == 1) begin
                checks++;
                if ({s0_bvalid, s1_bvalid, s0_bid} !== {1'b1, 1'b0, 4'h6}) begin
                    errors++;
                    $display("FAIL concurrent_b: got %h expected %h", {s0_bvalid, s1_bvalid, s0_bid}, {1'b1, 1'b0, 4'h6});
                end
            end
            tick();
        end
        clear_inputs();
        s1_rready = 1;
        settle();
        checks++;
        if ({s1_rvalid, m_rready, m_bready} !== 3'b000) begin
            errors++;
            $display("FAIL concurrent_done: got %b expected 000", {s1_rvalid, m_rready, m_bready});
        end
        s1_rready = 0;
    endtask

    task automatic test_wlast_err();
        s0_awvalid = 1; s0_awid = 4'h8; s0_awaddr = 12'h140; s0_awlen = 8'd1;
        tick();
        m_awready = 1;
        tick();
        s0_awvalid = 0; m_awready = 0;
        s0_wvalid = 1; s0_wlast = 1; s0_wdata = 64'h77; m_wready = 1;
        settle();
        checks++;
        if ({err_wlast, m_wvalid} !== 2'b01) begin
            errors++;
            $display("FAIL wlast_before: got %b expected 01", {err_wlast, m_wvalid});
        end
        tick();
        s0_wlast = 0;
        settle();
        checks++;
        if ({err_wlast, s0_wready, m_wvalid} !== 3'b100) begin
            errors++;
            $display("FAIL wlast_pulse_end: got %b expected 100", {err_wlast, s0_wready, m_wvalid});
        end
        s0_wvalid = 0; m_wready = 0;
        m_bvalid = 1; m_bid = 4'h8; s0_bready = 1;
        settle();
        checks++;
        if ({s0_bvalid, s0_bid} !== {1'b1, 4'h8}) begin
            errors++;
            $display("FAIL wlast_b: got %h expected %h", {s0_bvalid, s0_bid}, {1'b1, 4'h8});
        end
        tick();
        checks++;
        if (err_wlast !== 1'b0) begin
            errors++;
            $display("FAIL wlast_single_pulse: got %b expected 0", err_wlast);
        end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        logic [15:0] pat;
        int k;
        int errs_seen;
        pat = 16'b1101_0110_1011_1001;
        k = 0;
        errs_seen = 0;
        s0_awvalid = 1; s0_awid = 4'h7; s0_awaddr = 12'h180; s0_awlen = 8'd3;
        tick();
        for (int c = 0; c < 3; c++) begin
            settle();
            checks++;
            if ({m_awvalid, s0_awready} !== 2'b10) begin
                errors++;
                $display("FAIL bp_aw_hold%0d: got %b expected 10", c, {m_awvalid, s0_awready});
            end
            tick();
        end
        m_awready = 1;
        tick();
        s0_awvalid = 0; m_awready = 0;
        for (int cyc = 0; cyc < 60 && k < 4; cyc++) begin
            s0_wvalid = 1; s0_wdata = 64'hA0 + 64'(k); s0_wlast = (k == 3);
            m_wready = pat[cyc % 16];
            settle();
            checks++;
            if ({m_wvalid, m_wdata} !== {1'b1, 64'hA0 + 64'(k)}) begin
                errors++;
                $display("FAIL bp_w_cyc%0d: got %h expected %h", cyc, {m_wvalid, m_wdata}, {1'b1, 64'hA0 + 64'(k)});
            end
            if (m_wready) k++;
            tick();
            if (err_wlast !== 1'b0) errs_seen++;
        end
        checks++;
        if (k != 4 || errs_seen != 0) begin
            errors++;
            $display("FAIL bp_w_beats: got %0d beats %0d errs expected 4 beats 0 errs", k, errs_seen);
        end
        s0_wvalid = 1; s0_wlast = 0; m_wready = 1;
        settle();
        checks++;
        if ({m_wvalid, s0_wready} !== 2'b00) begin
            errors++;
            $display("FAIL bp_w_no_extra: got %b expected 00", {m_wvalid, s0_wready});
        end
        s0_wvalid = 0; m_wready = 0;
        m_bvalid = 1; m_bid = 4'h7; s0_bready = 0;
        for (int c = 0; c < 5; c++) begin
            settle();
            checks++;
            if ({s0_bvalid, m_bready} !== 2'b10) begin
                errors++;
                $display("FAIL bp_b_hold%0d: got %b expected 10", c, {s0_bvalid, m_bready});
            end
            tick();
        end
        s0_bready = 1;
        settle();
        checks++;
        if ({s0_bvalid, m_bready, s0_bid} !== {1'b1, 1'b1, 4'h7}) begin
            errors++;
            $display("FAIL bp_b_accept: got %h expected %h", {s0_bvalid, m_bready, s0_bid}, {1'b1, 1'b1, 4'h7});
        end
        tick();
        m_bvalid = 0; s0_bready = 0;
        // read path with both slave and master stalls
        s0_arvalid = 1; s0_arid = 4'h9; s0_araddr = 12'h020; s0_arlen = 8'd3;
        tick();
        m_arready = 1;
        tick();
        s0_arvalid = 0; m_arready = 0;
        k = 0;
        for (int cyc = 0; cyc < 60 && k < 4; cyc++) begin
            m_rvalid = pat[(cyc + 3) % 16]; m_rdata = 64'hB0 + 64'(k); m_rlast = (k == 3); m_rid = 4'h9;
            s0_rready = pat[cyc % 16];
            settle();
            checks++;
            if ({s0_rvalid, m_rready, s0_rdata} !== {m_rvalid, s0_rready, 64'hB0 + 64'(k)}) begin
                errors++;
                $display("FAIL bp_r_cyc%0d: got %h expected %h", cyc, {s0_rvalid, m_rready, s0_rdata},
                         {m_rvalid, s0_rready, 64'hB0 + 64'(k)});
            end
            if (m_rvalid && s0_rready) k++;
            tick();
        end
        m_rvalid = 0; m_rlast = 0; s0_rready = 1;
        settle();
        checks++;
        if (k != 4 || m_rready !== 1'b0) begin
            errors++;
            $display("FAIL bp_r_done: got %0d beats rready %b expected 4 beats rready 0", k, m_rready);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_write();
        s0_awvalid = 1; s0_awid = 4'hA; s0_awaddr = 12'h1C0; s0_awlen = 8'd3;
        tick();
        m_awready = 1;
        tick();
        s0_awvalid = 0; m_awready = 0;
        s0_wvalid = 1; s0_wdata = 64'hC0; m_wready = 1;
        tick();
        s0_wdata = 64'hC1;
        reset = 1;
        tick();
        reset = 0;
        settle();
        checks++;
        if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, s0_wready, s0_awready, s0_bvalid, err_wlast} !== 9'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got %b expected 000000000",
                     {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, s0_wready, s0_awready, s0_bvalid, err_wlast});
        end
        clear_inputs();
        s0_awvalid = 1; s0_awaddr = 12'h111; s1_awvalid = 1; s1_awaddr = 12'h222;
        tick();
        checks++;
        if ({m_awvalid, m_awaddr} !== {1'b1, 12'h111}) begin
            errors++;
            $display("FAIL midreset_grant_s0: got %h expected %h", {m_awvalid, m_awaddr}, {1'b1, 12'h111});
        end
        do_reset();
    endtask

    initial begin
        reset = 1;
        clear_inputs();
        test_reset();
        test_single_write();
        test_contention();
        test_concurrent();
        test_wlast_err();
        test_backpressure();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
